// File: rtl/decode_regfile_sb.sv
// Decode-stage register file: icode-driven source decode, two bypassed read
// ports, two writeback ports and a per-register outstanding-write scoreboard.
module decode_regfile_sb #(
    parameter int                DATA_W   = 64,
    parameter int                NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter int                CNT_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic              issue_i,
    input  logic [3:0]        issue_dstE_i,
    input  logic [3:0]        issue_dstM_i,
    input  logic              wE_en_i,
    input  logic              wM_en_i,
    input  logic [3:0]        wE_dst_i,
    input  logic [3:0]        wM_dst_i,
    input  logic [DATA_W-1:0] wE_data_i,
    input  logic [DATA_W-1:0] wM_data_i,
    output logic [3:0]        srcA_o,
    output logic [3:0]        srcB_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    output logic              stall_o
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'd4;
    // Wide enough to hold cnt + 2 increments without wrapping.
    localparam int         SW    = CNT_W + 2;
    localparam logic [SW-1:0] CMAX = SW'((1 << CNT_W) - 1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic [SW-1:0]     dec_n  [NREG];
    logic [SW-1:0]     inc_n  [NREG];
    logic [SW-1:0]     sum_n  [NREG];
    logic [NREG-1:0]   hit_e;
    logic [NREG-1:0]   hit_m;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   ovf;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic              stall;

    function automatic logic id_ok(input logic [3:0] id);
        return (id != RNONE) && (int'(id) < NREG);
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        case (icode_i)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = rA_i;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
        case (icode_i)
            4'h4, 4'h5, 4'h6:       src_b = rB_i;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
    end

    // Per-register writeback hits, pending issue increments and stall terms.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            hit_e[i] = wE_en_i && (wE_dst_i == 4'(i));
            hit_m[i] = wM_en_i && (wM_dst_i == 4'(i));
            dec_n[i] = SW'(hit_e[i]) + SW'(hit_m[i]);
            inc_n[i] = SW'(issue_dstE_i == 4'(i)) + SW'(issue_dstM_i == 4'(i));
            busy[i]  = SW'(cnt_q[i]) > dec_n[i];
            ovf[i]   = (inc_n[i] != '0) && ((SW'(cnt_q[i]) + inc_n[i]) > (dec_n[i] + CMAX));
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!rst_i) begin
            stall = (id_ok(src_a) && busy[src_a])
                 || (id_ok(src_b) && busy[src_b])
                 || (|ovf);
        end
    end

    always_comb begin
        valA_o = '0;
        valB_o = '0;
        if (!rst_i && id_ok(src_a)) begin
            if (hit_m[src_a])      valA_o = wM_data_i;
            else if (hit_e[src_a]) valA_o = wE_data_i;
            else                   valA_o = regs_q[src_a];
        end
        if (!rst_i && id_ok(src_b)) begin
            if (hit_m[src_b])      valB_o = wM_data_i;
            else if (hit_e[src_b]) valB_o = wE_data_i;
            else                   valB_o = regs_q[src_b];
        end
    end

    // Increments and decrements net out in one update, clamped at zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sum_n[i]  = SW'(cnt_q[i]) + ((issue_i && !stall) ? inc_n[i] : '0);
            cnt_d[i]  = (sum_n[i] > dec_n[i]) ? CNT_W'(sum_n[i] - dec_n[i]) : '0;
            regs_d[i] = hit_m[i] ? wM_data_i : (hit_e[i] ? wE_data_i : regs_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst_i) begin
                regs_q[i] <= (i == int'(RSP)) ? RSP_INIT : '0;
                cnt_q[i]  <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign srcA_o  = src_a;
    assign srcB_o  = src_b;
    assign stall_o = stall;

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Self-checking bench for decode_regfile_sb: table-driven decode sweep,
// directed scoreboard/reset sequences and a randomized run against a model.
module tb_decode_regfile_sb;

    localparam int          DATA_W   = 64;
    localparam int          NREG     = 15;
    localparam logic [63:0] RSP_INIT = 64'hDEAD_BEEF_0000_0040;
    localparam int          CNT_W    = 2;
    localparam int          CMAXI    = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  icode_i, rA_i, rB_i;
    logic        issue_i;
    logic [3:0]  issue_dstE_i, issue_dstM_i;
    logic        wE_en_i, wM_en_i;
    logic [3:0]  wE_dst_i, wM_dst_i;
    logic [63:0] wE_data_i, wM_data_i;
    logic [3:0]  srcA_o, srcB_o;
    logic [63:0] valA_o, valB_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_regs [NREG];
    int          m_cnt  [NREG];

    always #5 clk = ~clk;

    decode_regfile_sb #(
        .DATA_W(DATA_W), .NREG(NREG), .RSP_INIT(RSP_INIT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .issue_i(issue_i), .issue_dstE_i(issue_dstE_i), .issue_dstM_i(issue_dstM_i),
        .wE_en_i(wE_en_i), .wM_en_i(wM_en_i), .wE_dst_i(wE_dst_i), .wM_dst_i(wM_dst_i),
        .wE_data_i(wE_data_i), .wM_data_i(wM_data_i),
        .srcA_o(srcA_o), .srcB_o(srcB_o), .valA_o(valA_o), .valB_o(valB_o),
        .stall_o(stall_o)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  exp_a;
        logic [3:0]  exp_b;
        logic [63:0] exp_va;
        logic [63:0] exp_vb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        case (ic)
            4'h2, 4'h4, 4'h6, 4'hA: return ra;
            4'h9, 4'hB:             return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        case (ic)
            4'h4, 4'h5, 4'h6:       return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic bit ok(input logic [3:0] id);
        return int'(id) < NREG;
    endfunction

    function automatic int wbcnt(input int r);
        return ((wE_en_i && int'(wE_dst_i) == r) ? 1 : 0) + ((wM_en_i && int'(wM_dst_i) == r) ? 1 : 0);
    endfunction

    function automatic int isscnt(input int r);
        return ((int'(issue_dstE_i) == r) ? 1 : 0) + ((int'(issue_dstM_i) == r) ? 1 : 0);
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] s);
        if (rst_i || !ok(s)) return 64'h0;
        if (wM_en_i && wM_dst_i == s) return wM_data_i;
        if (wE_en_i && wE_dst_i == s) return wE_data_i;
        return m_regs[s];
    endfunction

    function automatic logic m_stall();
        logic [3:0] sa, sb;
        if (rst_i) return 1'b0;
        sa = m_srcA(icode_i, rA_i);
        sb = m_srcB(icode_i, rB_i);
        if (ok(sa) && m_cnt[sa] - wbcnt(int'(sa)) > 0) return 1'b1;
        if (ok(sb) && m_cnt[sb] - wbcnt(int'(sb)) > 0) return 1'b1;
        if (ok(issue_dstE_i) && m_cnt[issue_dstE_i] + isscnt(int'(issue_dstE_i)) - wbcnt(int'(issue_dstE_i)) > CMAXI) return 1'b1;
        if (ok(issue_dstM_i) && m_cnt[issue_dstM_i] + isscnt(int'(issue_dstM_i)) - wbcnt(int'(issue_dstM_i)) > CMAXI) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_commit();
        logic st;
        int   n;
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = (r == 4) ? RSP_INIT : 64'h0;
                m_cnt[r]  = 0;
            end
        end else begin
            st = m_stall();
            for (int r = 0; r < NREG; r++) begin
                n = m_cnt[r] + ((issue_i && !st) ? isscnt(r) : 0) - wbcnt(r);
                m_cnt[r] = (n < 0) ? 0 : n;
            end
            if (wE_en_i && ok(wE_dst_i)) m_regs[wE_dst_i] = wE_data_i;
            if (wM_en_i && ok(wM_dst_i)) m_regs[wM_dst_i] = wM_data_i;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rst_i = 1'b0; icode_i = 4'h0; rA_i = 4'hF; rB_i = 4'hF;
        issue_i = 1'b0; issue_dstE_i = 4'hF; issue_dstM_i = 4'hF;
        wE_en_i = 1'b0; wM_en_i = 1'b0; wE_dst_i = 4'hF; wM_dst_i = 4'hF;
        wE_data_i = 64'h0; wM_data_i = 64'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    task automatic wb_e(input logic [3:0] d, input logic [63:0] v);
        wE_en_i = 1'b1; wE_dst_i = d; wE_data_i = v;
    endtask

    function automatic logic [3:0] pick_dst();
        int off;
        if ($urandom_range(0, 3) != 0) begin
            off = $urandom_range(0, NREG - 1);
            for (int k = 0; k < NREG; k++)
                if (m_cnt[(off + k) % NREG] > 0) return 4'((off + k) % NREG);
        end
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] pick_issue();
        return ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = 64'h0;
            m_cnt[r]  = 0;
        end
        vecs[0]  = '{4'h0, 4'hF, 4'hF, 64'h0,   64'h0};
        vecs[1]  = '{4'h1, 4'hF, 4'hF, 64'h0,   64'h0};
        vecs[2]  = '{4'h2, 4'h1, 4'hF, 64'h101, 64'h0};
        vecs[3]  = '{4'h3, 4'hF, 4'hF, 64'h0,   64'h0};
        vecs[4]  = '{4'h4, 4'h1, 4'h2, 64'h101, 64'h202};
        vecs[5]  = '{4'h5, 4'hF, 4'h2, 64'h0,   64'h202};
        vecs[6]  = '{4'h6, 4'h1, 4'h2, 64'h101, 64'h202};
        vecs[7]  = '{4'h7, 4'hF, 4'hF, 64'h0,   64'h0};
        vecs[8]  = '{4'h8, 4'hF, 4'h4, 64'h0,   RSP_INIT};
        vecs[9]  = '{4'h9, 4'h4, 4'h4, RSP_INIT, RSP_INIT};
        vecs[10] = '{4'hA, 4'h1, 4'h4, 64'h101, RSP_INIT};
        vecs[11] = '{4'hB, 4'h4, 4'h4, RSP_INIT, RSP_INIT};

        idle();
        @(negedge clk);

        // Reset, then PUSHQ rA=0
        rst_i = 1'b1; icode_i = 4'hA; rA_i = 4'h0; #1;
        chk("rst_valA", valA_o, 64'h0);
        chk("rst_valB", valB_o, 64'h0);
        chk("rst_stall", {63'h0, stall_o}, 64'h0);
        $display("txn reset asserted");
        tick();
        rst_i = 1'b0; #1;
        chk("post_rst_srcA", {60'h0, srcA_o}, 64'h0);
        chk("post_rst_srcB", {60'h0, srcB_o}, 64'h4);
        chk("post_rst_valA", valA_o, 64'h0);
        chk("post_rst_valB", valB_o, RSP_INIT);
        chk("post_rst_stall", {63'h0, stall_o}, 64'h0);
        $display("txn pushq after reset valB=%h", valB_o);
        tick();

        // Dual writeback to the same register, M wins
        idle(); icode_i = 4'h6; rA_i = 4'h3;
        wb_e(4'h3, 64'h11); wM_en_i = 1'b1; wM_dst_i = 4'h3; wM_data_i = 64'h22; #1;
        chk("bypass_valA", valA_o, 64'h22);
        $display("txn bypass valA=%h", valA_o);
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h3; #1;
        chk("stored_valA", valA_o, 64'h22);
        $display("txn stored valA=%h", valA_o);
        tick();

        // Decode sweep
        idle(); wb_e(4'h1, 64'h101); wM_en_i = 1'b1; wM_dst_i = 4'h2; wM_data_i = 64'h202;
        tick();
        for (int v = 0; v < 12; v++) begin
            idle(); icode_i = vecs[v].icode; rA_i = 4'h1; rB_i = 4'h2; #1;
            chk($sformatf("dec%0d_srcA", v), {60'h0, srcA_o}, {60'h0, vecs[v].exp_a});
            chk($sformatf("dec%0d_srcB", v), {60'h0, srcB_o}, {60'h0, vecs[v].exp_b});
            chk($sformatf("dec%0d_valA", v), valA_o, vecs[v].exp_va);
            chk($sformatf("dec%0d_valB", v), valB_o, vecs[v].exp_vb);
            $display("txn decode icode=%h srcA=%h srcB=%h", icode_i, srcA_o, srcB_o);
            tick();
        end

        // Scoreboard hazard and release by writeback
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h5; #1;
        chk("sb_issue_stall", {63'h0, stall_o}, 64'h0);
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; #1;
        chk("sb_busy_stall", {63'h0, stall_o}, 64'h1);
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; wb_e(4'h5, 64'h99); #1;
        chk("sb_release_stall", {63'h0, stall_o}, 64'h0);
        chk("sb_release_valA", valA_o, 64'h99);
        $display("txn scoreboard release valA=%h", valA_o);
        tick();

        // Saturation on r7
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h7; issue_dstM_i = 4'h7; #1;
        chk("sat_issue2", {63'h0, stall_o}, 64'h0);
        tick();
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h7; #1;
        chk("sat_issue3", {63'h0, stall_o}, 64'h0);
        tick();
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h7; #1;
        chk("sat_overflow_stall", {63'h0, stall_o}, 64'h1);
        tick();
        idle(); issue_i = 1'b1; issue_dstM_i = 4'h7; #1;
        chk("sat_overflow_stall2", {63'h0, stall_o}, 64'h1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            idle(); icode_i = 4'h6; rA_i = 4'h7; wb_e(4'h7, 64'(k)); #1;
            chk($sformatf("sat_drain%0d_stall", k), {63'h0, stall_o}, (k == 3) ? 64'h0 : 64'h1);
            $display("txn saturation drain %0d stall=%0b", k, stall_o);
            tick();
        end
        idle(); icode_i = 4'h6; rA_i = 4'h7; #1;
        chk("sat_after_stall", {63'h0, stall_o}, 64'h0);
        chk("sat_after_valA", valA_o, 64'h3);
        tick();

        // Reset with in-flight writes, then a late writeback
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h5; issue_dstM_i = 4'h5;
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; #1;
        chk("mid_busy_stall", {63'h0, stall_o}, 64'h1);
        tick();
        idle(); rst_i = 1'b1; icode_i = 4'h6; rA_i = 4'h5; #1;
        chk("mid_rst_stall", {63'h0, stall_o}, 64'h0);
        chk("mid_rst_valA", valA_o, 64'h0);
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; wb_e(4'h5, 64'hAB); #1;
        chk("late_wb_stall", {63'h0, stall_o}, 64'h0);
        chk("late_wb_valA", valA_o, 64'hAB);
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; #1;
        chk("late_stored_stall", {63'h0, stall_o}, 64'h0);
        chk("late_stored_valA", valA_o, 64'hAB);
        tick();
        idle(); issue_i = 1'b1; issue_dstE_i = 4'h5;
        tick();
        idle(); icode_i = 4'h6; rA_i = 4'h5; #1;
        chk("late_reissue_stall", {63'h0, stall_o}, 64'h1);
        wb_e(4'h5, 64'hCD); #1;
        chk("late_reissue_release", {63'h0, stall_o}, 64'h0);
        $display("txn post-reset reissue release stall=%0b", stall_o);
        tick();

        // Randomized run against the model
        idle(); rst_i = 1'b1;
        tick();
        for (int c = 0; c < 400; c++) begin
            rst_i        = ($urandom_range(0, 99) == 0);
            icode_i      = 4'($urandom_range(0, 15));
            rA_i         = 4'($urandom_range(0, 15));
            rB_i         = 4'($urandom_range(0, 15));
            issue_i      = 1'($urandom_range(0, 1));
            issue_dstE_i = pick_issue();
            issue_dstM_i = pick_issue();
            wE_en_i      = 1'($urandom_range(0, 1));
            wM_en_i      = 1'($urandom_range(0, 1));
            wE_dst_i     = pick_dst();
            wM_dst_i     = pick_dst();
            wE_data_i    = {$urandom(), $urandom()};
            wM_data_i    = {$urandom(), $urandom()};
            #1;
            chk("rnd_srcA", {60'h0, srcA_o}, {60'h0, m_srcA(icode_i, rA_i)});
            chk("rnd_srcB", {60'h0, srcB_o}, {60'h0, m_srcB(icode_i, rB_i)});
            chk("rnd_valA", valA_o, m_read(m_srcA(icode_i, rA_i)));
            chk("rnd_valB", valB_o, m_read(m_srcB(icode_i, rB_i)));
            chk("rnd_stall", {63'h0, stall_o}, {63'h0, m_stall()});
            $display("txn rnd %0d icode=%h srcA=%h srcB=%h stall=%0b", c, icode_i, srcA_o, srcB_o, stall_o);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_regfile_sb.md
# decode_regfile_sb

Parametrised decode-stage register file for the Y86-64 core, successor to the fixed single-cycle `decode` block. It derives source registers from `icode`, serves two combinational read ports with write-first bypass, and accepts two writeback ports (E and M). A per-register outstanding-write scoreboard raises a stall when an issuing instruction reads a register that still has writes in flight. It sits between fetch and execute and is shared by the single-cycle and pipelined builds.

## Interface

Parameters:
- DATA_W, 64, register and data width
- NREG, 15, architectural registers (IDs 0..NREG-1); ID 4'hF is RNONE
- RSP_INIT, 64'h0, value loaded into %rsp (ID 4) on reset; all others reset to 0
- CNT_W, 2, width of each per-register outstanding-write counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- icode_i  in  4  instruction code of the decoding instruction
- rA_i, rB_i  in  4  register fields from fetch
- issue_i  in  1  instruction is issued this cycle (commits its scoreboard entries)
- issue_dstE_i, issue_dstM_i  in  4  destinations the issuing instruction will write (F = none)
- wE_en_i, wM_en_i  in  1  writeback enables
- wE_dst_i, wM_dst_i  in  4  writeback register IDs
- wE_data_i, wM_data_i  in  DATA_W  writeback data
- srcA_o, srcB_o  out  4  decoded source IDs
- valA_o, valB_o  out  DATA_W  read data
- stall_o  out  1  issue must be held this cycle

## Operation

- Source decode: srcA = rA for RRMOVQ(2), RMMOVQ(4), OPQ(6), PUSHQ(A); 4 (%rsp) for POPQ(B), RET(9); else F. srcB = rB for OPQ, RMMOVQ, MRMOVQ(5); 4 for PUSHQ, POPQ, CALL(8), RET; else F.
- Read: src F or src ≥ NREG returns 0. Otherwise bypass priority: wM match (wM_en_i, dst == src) > wE match > stored register.
- Write: on rising edge, wE then wM applied; if both target the same register, M wins. dst F or ≥ NREG ignored.
- Scoreboard: cnt[r] counts writes issued but not yet written back. On edge: +1 per issue_i destination (issue_dstE and issue_dstM both = r counts +2), −1 per enabled writeback to r. Net change applied in one update; a counter never goes below 0 (decrement at 0 ignored).
- stall_o = issue_i-independent: asserted when srcA or srcB (≠F) has cnt > 0 and no writeback to that register this cycle brings its count to 0, OR when any issue destination's counter would exceed 2^CNT_W−1. While stall_o is 1, issue_i is ignored (no counter increments).
- Reset (rst_i high at edge): all registers cleared, %rsp = RSP_INIT, all counters 0. While rst_i is high: writes and issues ignored, bypass disabled, valA_o/valB_o = 0, stall_o = 0.

## Timing

- Decode, read, bypass, stall: combinational, same cycle as inputs.
- Write latency: data visible in the same cycle through bypass; in storage from the next cycle.
- Scoreboard: issue at edge N sets busy from cycle N+1; writeback in cycle M clears stall in cycle M itself (bypass supplies data).
- Reset mid-operation: in-flight counts discarded; writebacks arriving after reset update storage but do not decrement (counter saturates at 0).

## Test plan

- Reset: rst_i=1 one edge, then icode=A(PUSHQ), rA=0 -> valA=0, valB=RSP_INIT, srcB=4, stall_o=0.
- Bypass: wE writes r3=0x11 and wM writes r3=0x22 same cycle, icode=6, rA=3 -> valA=0x22 that cycle; r3 holds 0x22 next cycle.
- Source decode sweep: all icodes 0..B with rA=1, rB=2 -> srcA/srcB per decode rules; RNONE reads 0.
- Scoreboard: issue dstE=5; next cycle OPQ rA=5 -> stall_o=1; wE to 5 with 0x99 -> stall_o=0, valA=0x99 same cycle.
- Saturation: CNT_W=2, issue dstE=dstM=7 then dstE=7 (cnt=3), further issue to 7 -> stall_o=1, counter stays 3.
- Reset with cnt[5]=2 -> after reset cnt=0; late wE to 5 writes data, no stall, counter stays 0.
